cpu_oci_dct_packer: RTL and testbench

- Sequences the CPU on-chip-instrumentation direct-control-trace (DCT) path.
- Accepts 2-bit branch/trace codes from the CPU trace logic and packs them into a 30-bit dct_buffer with occupancy dct_count.
- Schedules frame emission to the trace FIFO over a valid/ready handshake, on buffer full or on explicit flush.
- Holds one frame in an output register. Drops codes and flags overflow when the FIFO back-pressures.

---
 rtl/cpu_oci_dct_packer.sv | 157 +++++++++++++++
 tb/tb_cpu_oci_dct_packer.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/cpu_oci_dct_packer.sv
// Packs 2-bit DCT trace codes into 15-slot frames and hands them to the
// trace FIFO through a one-deep output register with a valid/ready handshake.
module cpu_oci_dct_packer #(
    parameter int CODE_W = 2,
    parameter int SLOTS  = 15,
    parameter int BUF_W  = 30,
    parameter int CNT_W  = 4
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   dct_en,
    input  logic                   code_valid,
    input  logic [CODE_W-1:0]      code,
    input  logic                   flush,
    input  logic                   overflow_clr,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [CNT_W+BUF_W-1:0] out_data,
    output logic [BUF_W-1:0]       dct_buffer,
    output logic [CNT_W-1:0]       dct_count,
    output logic                   overflow,
    output logic                   busy
);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        FILL       = 2'd1,
        FULL       = 2'd2,
        FLUSH_PEND = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(SLOTS);

    state_t                   state_r, state_s;
    logic [BUF_W-1:0]         buffer_r, buffer_s;
    logic [CNT_W-1:0]         count_r, count_s;
    logic                     out_valid_r, out_valid_s;
    logic [CNT_W+BUF_W-1:0]   out_data_r, out_data_s;
    logic                     overflow_r, overflow_s;

    logic                     free_s;
    logic                     in_code_s;
    logic                     accept_s;
    logic                     pend_req_s;
    logic                     emit_s;
    logic [BUF_W-1:0]         code_ext_s;
    logic [BUF_W-1:0]         app_buf_s;
    logic [CNT_W-1:0]         app_cnt_s;
    logic [CNT_W+BUF_W-1:0]   frame_s;

    // Accept/append/emit decision and next-state computation.
    always_comb begin
        free_s      = !out_valid_r || out_ready;
        in_code_s   = code_valid && dct_en;
        accept_s    = in_code_s && ((state_r != FULL) || free_s);
        pend_req_s  = flush || (state_r == FLUSH_PEND);
        code_ext_s  = {{(BUF_W-CODE_W){1'b0}}, code};
        app_buf_s   = buffer_r;
        app_cnt_s   = count_r;
        emit_s      = 1'b0;
        frame_s     = out_data_r;
        state_s     = state_r;
        buffer_s    = buffer_r;
        count_s     = count_r;

        if (accept_s && (state_r != FULL)) begin
            app_buf_s = buffer_r | (code_ext_s << (int'(count_r) * CODE_W));
            app_cnt_s = count_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            app_buf_s = buffer_r;
            app_cnt_s = count_r;
        end

        case (state_r)
            FULL: begin
                // The held frame leaves first; a same-cycle code starts the next one.
                if (free_s) begin
                    emit_s   = 1'b1;
                    frame_s  = {count_r, buffer_r};
                    buffer_s = accept_s ? code_ext_s : {BUF_W{1'b0}};
                    count_s  = accept_s ? {{(CNT_W-1){1'b0}}, 1'b1} : {CNT_W{1'b0}};
                    state_s  = accept_s ? FILL : IDLE;
                end else begin
                    state_s  = FULL;
                end
            end
            default: begin
                if (free_s && ((app_cnt_s == FULL_CNT) ||
                               (pend_req_s && (app_cnt_s != {CNT_W{1'b0}})))) begin
                    emit_s   = 1'b1;
                    frame_s  = {app_cnt_s, app_buf_s};
                    buffer_s = {BUF_W{1'b0}};
                    count_s  = {CNT_W{1'b0}};
                    state_s  = IDLE;
                end else begin
                    buffer_s = app_buf_s;
                    count_s  = app_cnt_s;
                    if (app_cnt_s == FULL_CNT) begin
                        state_s = FULL;
                    end else if (pend_req_s && (app_cnt_s != {CNT_W{1'b0}})) begin
                        state_s = FLUSH_PEND;
                    end else if (app_cnt_s == {CNT_W{1'b0}}) begin
                        state_s = IDLE;
                    end else begin
                        state_s = FILL;
                    end
                end
            end
        endcase

        if (emit_s) begin
            out_valid_s = 1'b1;
        end else if (out_ready) begin
            out_valid_s = 1'b0;
        end else begin
            out_valid_s = out_valid_r;
        end

        out_data_s = emit_s ? frame_s : out_data_r;

        // A drop in the same cycle as a clear keeps the flag set.
        if (in_code_s && !accept_s) begin
            overflow_s = 1'b1;
        end else if (overflow_clr) begin
            overflow_s = 1'b0;
        end else begin
            overflow_s = overflow_r;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r     <= IDLE;
            buffer_r    <= {BUF_W{1'b0}};
            count_r     <= {CNT_W{1'b0}};
            out_valid_r <= 1'b0;
            out_data_r  <= {(CNT_W+BUF_W){1'b0}};
            overflow_r  <= 1'b0;
        end else begin
            state_r     <= state_s;
            buffer_r    <= buffer_s;
            count_r     <= count_s;
            out_valid_r <= out_valid_s;
            out_data_r  <= out_data_s;
            overflow_r  <= overflow_s;
        end
    end

    assign out_valid  = out_valid_r;
    assign out_data   = out_data_r;
    assign dct_buffer = buffer_r;
    assign dct_count  = count_r;
    assign overflow   = overflow_r;
    assign busy       = (state_r != IDLE) || out_valid_r;

endmodule

// File: tb/tb_cpu_oci_dct_packer.sv
// Directed bench for cpu_oci_dct_packer: a queue-based frame model is compared
// against the DUT every cycle, plus literal expectations for the key scenarios.
module tb_cpu_oci_dct_packer;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        dct_en, code_valid, flush, overflow_clr, out_ready;
    logic [1:0]  code;
    logic        out_valid, overflow, busy;
    logic [33:0] out_data;
    logic [29:0] dct_buffer;
    logic [3:0]  dct_count;

    int checks = 0;
    int errors = 0;

    cpu_oci_dct_packer dut (
        .clk(clk), .reset_n(reset_n), .dct_en(dct_en), .code_valid(code_valid),
        .code(code), .flush(flush), .overflow_clr(overflow_clr),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .dct_buffer(dct_buffer), .dct_count(dct_count), .overflow(overflow),
        .busy(busy)
    );

    always #5 clk = ~clk;

    // Model: pending codes in arrival order, the held frame, sticky flags.
    int          q[$];
    bit          m_hv = 1'b0;
    logic [33:0] m_hd = 34'd0;
    bit          m_ov = 1'b0;
    bit          m_pend = 1'b0;

    function automatic logic [33:0] frame_of();
        logic [29:0] b;
        b = 30'd0;
        for (int i = 0; i < q.size(); i++) b = b + (30'(q[i]) << (2 * i));
        return {4'(q.size()), b};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge reset_n) begin
        q.delete();
        m_hv = 1'b0; m_hd = 34'd0; m_ov = 1'b0; m_pend = 1'b0;
    end

    always @(posedge clk) begin
        if (reset_n) begin
            bit free, inc, emitted, drop, want;
            free = !m_hv || out_ready;
            inc = code_valid && dct_en;
            emitted = 1'b0;
            drop = 1'b0;
            if (q.size() == 15) begin
                m_pend = 1'b0;
                if (free) begin
                    m_hd = frame_of();
                    emitted = 1'b1;
                    q.delete();
                    if (inc) q.push_back(int'(code));
                end else if (inc) begin
                    drop = 1'b1;
                end
            end else begin
                if (inc) q.push_back(int'(code));
                want = (q.size() == 15) || ((flush || m_pend) && q.size() > 0);
                if (free && want) begin
                    m_hd = frame_of();
                    emitted = 1'b1;
                    q.delete();
                    m_pend = 1'b0;
                end else begin
                    m_pend = (q.size() != 15) && (flush || m_pend) && (q.size() > 0);
                end
            end
            if (emitted) m_hv = 1'b1;
            else if (out_ready) m_hv = 1'b0;
            if (drop) m_ov = 1'b1;
            else if (overflow_clr) m_ov = 1'b0;
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        if (reset_n) begin
            logic [33:0] f;
            f = frame_of();
            chk("model_out_valid", 64'(out_valid), 64'(m_hv));
            chk("model_out_data", 64'(out_data), 64'(m_hd));
            chk("model_buffer", 64'(dct_buffer), 64'(f[29:0]));
            chk("model_count", 64'(dct_count), 64'(q.size()));
            chk("model_overflow", 64'(overflow), 64'(m_ov));
            chk("model_busy", 64'(busy), 64'((q.size() > 0) || m_hv));
        end
    end

    task automatic cyc(input logic cv, input logic [1:0] c, input logic fl, input logic clr);
        code_valid = cv; code = c; flush = fl; overflow_clr = clr;
        @(posedge clk);
        #1;
        code_valid = 1'b0; flush = 1'b0; overflow_clr = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0; dct_en = 1'b1; code_valid = 1'b0; code = 2'd0;
        flush = 1'b0; overflow_clr = 1'b0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_out_valid", 64'(out_valid), 64'd0);
        chk("reset_out_data", 64'(out_data), 64'd0);
        chk("reset_count", 64'(dct_count), 64'd0);
        chk("reset_busy", 64'(busy), 64'd0);
        reset_n = 1'b1;
        cyc(1'b0, 2'd0, 1'b0, 1'b0);

        // Full frame, back-to-back codes 0,1,2,3,...
        for (int i = 0; i < 15; i++) cyc(1'b1, 2'(i % 4), 1'b0, 1'b0);
        chk("fill_valid", 64'(out_valid), 64'd1);
        chk("fill_data", 64'(out_data), 64'h3E4E4E4E4);
        chk("fill_count", 64'(dct_count), 64'd0);
        cyc(1'b0, 2'd0, 1'b0, 1'b0);
        chk("fill_drained", 64'(out_valid), 64'd0);

        // Partial flush.
        cyc(1'b1, 2'd3, 1'b0, 1'b0);
        cyc(1'b1, 2'd3, 1'b0, 1'b0);
        cyc(1'b1, 2'd1, 1'b0, 1'b0);
        cyc(1'b0, 2'd0, 1'b1, 1'b0);
        chk("flush_data", 64'(out_data), 64'({4'd3, 30'h1F}));
        cyc(1'b0, 2'd0, 1'b0, 1'b0);

        // Empty flush emits nothing; disabled codes are ignored.
        cyc(1'b0, 2'd0, 1'b1, 1'b0);
        chk("empty_flush", 64'(out_valid), 64'd0);
        dct_en = 1'b0;
        cyc(1'b1, 2'd3, 1'b0, 1'b0);
        chk("dct_en_low", 64'(dct_count), 64'd0);
        dct_en = 1'b1;

        // Code and flush together.
        cyc(1'b1, 2'd1, 1'b0, 1'b0);
        cyc(1'b1, 2'd3, 1'b0, 1'b0);
        cyc(1'b1, 2'd2, 1'b1, 1'b0);
        chk("simul_data", 64'(out_data), 64'({4'd3, 30'h2D}));
        chk("simul_count", 64'(dct_count), 64'd0);
        cyc(1'b0, 2'd0, 1'b0, 1'b0);

        // Back-pressure into FULL, then overflow.
        out_ready = 1'b0;
        for (int i = 0; i < 30; i++) cyc(1'b1, 2'(i % 4), 1'b0, 1'b0);
        chk("bp_first_valid", 64'(out_valid), 64'd1);
        chk("bp_first_data", 64'(out_data), 64'h3E4E4E4E4);
        chk("bp_full_count", 64'(dct_count), 64'd15);
        chk("bp_no_overflow", 64'(overflow), 64'd0);
        cyc(1'b1, 2'd3, 1'b0, 1'b0);
        chk("bp_overflow", 64'(overflow), 64'd1);
        out_ready = 1'b1;
        cyc(1'b0, 2'd0, 1'b0, 1'b0);
        chk("bp_second_valid", 64'(out_valid), 64'd1);
        chk("bp_second_cnt", 64'(out_data[33:30]), 64'd15);
        chk("bp_count_clear", 64'(dct_count), 64'd0);
        cyc(1'b0, 2'd0, 1'b0, 1'b1);
        chk("bp_overflow_clr", 64'(overflow), 64'd0);

        // Pending flush completes once the output register frees up.
        out_ready = 1'b0;
        cyc(1'b1, 2'd2, 1'b0, 1'b0);
        cyc(1'b0, 2'd0, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) cyc(1'b1, 2'd1, 1'b0, 1'b0);
        cyc(1'b0, 2'd0, 1'b1, 1'b0);
        cyc(1'b1, 2'd1, 1'b0, 1'b0);
        cyc(1'b1, 2'd1, 1'b0, 1'b0);
        chk("pend_count", 64'(dct_count), 64'd7);
        out_ready = 1'b1;
        cyc(1'b0, 2'd0, 1'b0, 1'b0);
        chk("pend_data", 64'(out_data), 64'({4'd7, 30'h1555}));
        cyc(1'b0, 2'd0, 1'b0, 1'b0);

        // Asynchronous reset in the middle of a frame.
        for (int i = 0; i < 9; i++) cyc(1'b1, 2'd2, 1'b0, 1'b0);
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst_count", 64'(dct_count), 64'd0);
        chk("arst_buffer", 64'(dct_buffer), 64'd0);
        chk("arst_data", 64'(out_data), 64'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        repeat (3) cyc(1'b0, 2'd0, 1'b0, 1'b0);
        chk("arst_no_frame", 64'(out_valid), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
